// File: rtl/rshift_seq_pkg.sv
// Shared definitions for the multi-cycle right-shift sequencer: FSM states,
// per-cycle step limit and the shift-amount width derivation.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STEP_MAX = 3;

    function automatic int amt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/rshift_seq_if.sv
// Job request / result handshake bundle between a requester (master) and the
// shift sequencer (slave).
interface rshift_seq_if #(
    parameter int WIDTH = 8
);
    import shift_pkg::*;

    localparam int AMT_W = amt_width(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_rot;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_amt, in_rot, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_rot, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/rshift_seq_stage.sv
// Combinational right shift by 0..3 positions, zero fill or wrap-around,
// built from a shift-by-1 rank followed by a shift-by-2 rank. No state.
module rshift_stage #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_step,
    input  logic             i_rot,
    output logic [WIDTH-1:0] o_data
);
    logic [WIDTH-1:0] w_s1;
    logic             w_fill1;
    logic [1:0]       w_fill2;

    always_comb begin
        w_fill1 = i_rot ? i_data[0] : 1'b0;
        w_s1    = i_step[0] ? {w_fill1, i_data[WIDTH-1:1]} : i_data;
        w_fill2 = i_rot ? w_s1[1:0] : 2'b00;
        o_data  = i_step[1] ? {w_fill2, w_s1[WIDTH-1:2]} : w_s1;
    end

endmodule

// File: rtl/rshift_seq.sv
// Iterative right shifter: one job at a time, result after 1 + ceil(amt/3) cycles;
// the result is held in DONE until out_ready, and no job is accepted outside IDLE.
module rshift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    rshift_seq_if.slave  bus
);
    localparam int AMT_W = amt_width(WIDTH);

    state_t           r_state;
    logic             r_out_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_acc;
    logic [AMT_W-1:0] r_rem;
    logic             r_rot;

    state_t           w_state_nxt;
    logic [AMT_W-1:0] w_step;
    logic [AMT_W-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_stage;

    // Clamp the remaining amount to what a single stage pass can cover.
    always_comb begin
        w_step    = (r_rem >= AMT_W'(STEP_MAX)) ? AMT_W'(STEP_MAX) : r_rem;
        w_rem_nxt = r_rem - w_step;
    end

    rshift_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .i_data (r_acc),
        .i_step (w_step[1:0]),
        .i_rot  (r_rot),
        .o_data (w_stage)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_state_nxt = (bus.in_amt == '0) ? DONE : RUN;
            RUN:     if (w_rem_nxt == '0) w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // out_valid and busy come straight from flops so out_ready never reaches them combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_rem <= '0;
            r_rot <= 1'b0;
        end else if (r_state == IDLE && bus.in_valid) begin
            r_acc <= bus.in_data;
            r_rem <= bus.in_amt;
            r_rot <= bus.in_rot;
        end else if (r_state == RUN) begin
            r_acc <= w_stage;
            r_rem <= w_rem_nxt;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.out_data  = r_acc;

endmodule
